// File: rtl/pmp_csr_file_if.sv
// riscv package (PMP cfg byte type) and the CSR request/response interface.
// Ports (pmp_csr_file_if): req_valid/req_ready/req_we/req_addr/req_wdata carry a CSR
//   access from the CSR unit; resp_valid/resp_ready/resp_rdata/resp_err carry its answer.
// Modports: master = CSR unit side, slave = pmp_csr_file side.

package riscv;

  // One PMP configuration byte, MSB first: L, reserved[1:0], A[1:0], X, W, R.
  typedef struct packed {
    logic       locked;
    logic [1:0] reserved;
    logic [1:0] addr_mode;
    logic       x;
    logic       w;
    logic       r;
  } pmpcfg_t;

  localparam logic [1:0] A_OFF   = 2'b00;
  localparam logic [1:0] A_TOR   = 2'b01;
  localparam logic [1:0] A_NA4   = 2'b10;
  localparam logic [1:0] A_NAPOT = 2'b11;

endpackage

interface pmp_csr_file_if #(
  parameter int unsigned XLEN = 32
);
  logic            req_valid;
  logic            req_ready;
  logic            req_we;
  logic [11:0]     req_addr;
  logic [XLEN-1:0] req_wdata;
  logic            resp_valid;
  logic            resp_ready;
  logic [XLEN-1:0] resp_rdata;
  logic            resp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/pmp_csr_file.sv
// Purpose: PMP cfg/addr CSR storage with lock, reserved-bit and WARL rules; feeds PMP checkers.
// Latency: response (and conf/conf_addr/flush update) one cycle after request acceptance.
// Backpressure: one outstanding request; req_ready = !resp_valid || resp_ready.
//
// Ports: clk, rst_n (async, active-low); bus (pmp_csr_file_if.slave) request/response channel;
//   conf_addr[15:0] stored pmpaddr values; conf[15:0] cfg bytes; flush one-cycle pulse
//   after any write that changed stored state.
// Optional feature macro: PMP_CSR_WARL_RW_EN -- when defined, R=0/W=1 is stored with W=0
//   and A=NA4 is stored as OFF; when undefined, fields are stored as written (reserved bits
//   always cleared).

module pmp_csr_file #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned PMP_LEN    = 32,
  parameter int unsigned NR_ENTRIES = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  pmp_csr_file_if.slave                bus,
  output logic [15:0][PMP_LEN-1:0]     conf_addr,
  output riscv::pmpcfg_t [15:0]        conf,
  output logic                         flush
);

  localparam int unsigned NBYTES = XLEN / 8;
  // Entry count as a 5-bit value so it compares cleanly against 4-bit entry indices.
  localparam logic [4:0]  NR     = 5'(NR_ENTRIES);

`ifdef PMP_CSR_WARL_RW_EN
  localparam bit WARL_EN = 1'b1;
`else
  localparam bit WARL_EN = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  riscv::pmpcfg_t [15:0]       cfg_q, cfg_d;
  logic [15:0][PMP_LEN-1:0]    addr_q, addr_d;

  logic                        resp_valid_q;
  logic [XLEN-1:0]             resp_rdata_q;
  logic                        resp_err_q;
  logic                        flush_q;

  // --------------------------------------------------------------------------
  // Handshake
  // --------------------------------------------------------------------------
  logic accept;

  assign bus.req_ready = !resp_valid_q || bus.resp_ready;
  assign accept        = bus.req_valid && bus.req_ready;

  // --------------------------------------------------------------------------
  // Address decode
  // --------------------------------------------------------------------------
  logic        is_cfg;
  logic        is_addr;
  logic        is_err;
  logic [3:0]  cfg_base;   // first entry held by the addressed pmpcfg CSR
  logic [3:0]  addr_idx;   // pmpaddr entry index

  always_comb begin
    if (XLEN == 64) begin
      // Only even pmpcfg CSRs exist on rv64.
      is_cfg = (bus.req_addr == 12'h3A0) || (bus.req_addr == 12'h3A2);
    end else begin
      is_cfg = (bus.req_addr[11:2] == 10'h0E8);
    end
    is_addr  = (bus.req_addr[11:4] == 8'h3B);
    is_err   = !is_cfg && !is_addr;
    cfg_base = {bus.req_addr[1:0], 2'b00};
    addr_idx = bus.req_addr[3:0];
  end

  // --------------------------------------------------------------------------
  // Cfg byte legalisation
  // --------------------------------------------------------------------------
  function automatic riscv::pmpcfg_t legalize(input logic [7:0] raw);
    riscv::pmpcfg_t c;
    c          = riscv::pmpcfg_t'(raw);
    c.reserved = 2'b00;
    if (WARL_EN) begin
      if (!c.r && c.w) begin
        c.w = 1'b0;
      end
      if (c.addr_mode == riscv::A_NA4) begin
        c.addr_mode = riscv::A_OFF;
      end
    end
    return c;
  endfunction

  // --------------------------------------------------------------------------
  // Next state. Lock checks always look at the registered cfg, so an L bit written
  // by this request only protects the entry from later requests.
  // --------------------------------------------------------------------------
  logic [3:0] wr_e;
  logic       addr_locked;

  always_comb begin
    cfg_d       = cfg_q;
    addr_d      = addr_q;
    wr_e        = 4'd0;
    addr_locked = 1'b0;

    if (accept && bus.req_we && is_cfg) begin
      for (int b = 0; b < NBYTES; b++) begin
        wr_e = cfg_base + 4'(b);
        if (({1'b0, wr_e} < NR) && !cfg_q[wr_e].locked) begin
          cfg_d[wr_e] = legalize(bus.req_wdata[8*b +: 8]);
        end
      end
    end

    if (accept && bus.req_we && is_addr) begin
      // A locked TOR entry above also freezes this entry, since it is that
      // entry's lower bound.
      addr_locked = cfg_q[addr_idx].locked;
      if (addr_idx != 4'd15) begin
        if (cfg_q[addr_idx + 4'd1].locked &&
            (cfg_q[addr_idx + 4'd1].addr_mode == riscv::A_TOR)) begin
          addr_locked = 1'b1;
        end
      end
      if (({1'b0, addr_idx} < NR) && !addr_locked) begin
        addr_d[addr_idx] = bus.req_wdata[PMP_LEN-1:0];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Read data: taken from the next-state values so a write returns the
  // post-write register contents; for reads next-state equals current state.
  // --------------------------------------------------------------------------
  logic [XLEN-1:0] rd_data;
  logic [3:0]      rd_e;

  always_comb begin
    rd_data = '0;
    rd_e    = 4'd0;
    if (is_cfg) begin
      for (int b = 0; b < NBYTES; b++) begin
        rd_e                = cfg_base + 4'(b);
        rd_data[8*b +: 8]   = cfg_d[rd_e];
      end
    end else if (is_addr) begin
      rd_data[PMP_LEN-1:0] = addr_d[addr_idx];
    end
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_q        <= '0;
      addr_q       <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
      flush_q      <= 1'b0;
    end else begin
      cfg_q   <= cfg_d;
      addr_q  <= addr_d;
      // Checkers only need flushing when something they consume actually changed.
      flush_q <= accept && bus.req_we && ((cfg_d != cfg_q) || (addr_d != addr_q));
      if (accept) begin
        resp_valid_q <= 1'b1;
        resp_rdata_q <= rd_data;
        resp_err_q   <= is_err;
      end else if (bus.resp_ready) begin
        resp_valid_q <= 1'b0;
      end
    end
  end

  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_err   = resp_err_q;
  assign flush          = flush_q;
  assign conf           = cfg_q;
  assign conf_addr      = addr_q;

endmodule

// File: tb/tb_pmp_csr_file.sv
// Scoreboard bench for pmp_csr_file (XLEN=32, PMP_LEN=32, NR_ENTRIES=4).
// The driver pushes the hand-computed response for each request; a monitor pops
// and compares whenever a response is consumed.

module tb_pmp_csr_file;

  localparam int XLEN    = 32;
  localparam int PMP_LEN = 32;
  localparam int NR      = 4;

`ifdef PMP_CSR_WARL_RW_EN
  localparam logic [7:0] CFG_W_ONLY = 8'h00;
  localparam logic [7:0] CFG_NA4    = 8'h00;
`else
  localparam logic [7:0] CFG_W_ONLY = 8'h02;
  localparam logic [7:0] CFG_NA4    = 8'h10;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pmp_csr_file_if #(.XLEN(XLEN)) bus ();

  logic [15:0][PMP_LEN-1:0] conf_addr;
  riscv::pmpcfg_t [15:0]    conf;
  logic                     flush;

  pmp_csr_file #(
    .XLEN(XLEN),
    .PMP_LEN(PMP_LEN),
    .NR_ENTRIES(NR)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus),
    .conf_addr(conf_addr),
    .conf(conf),
    .flush(flush)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        fl;
    int          tag;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   tag_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- monitor ----------------
  exp_t mon_e;
  logic held        = 1'b0;
  logic first_flush = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        held = 1'b0;
      end else begin
        if (bus.resp_valid && !held) begin
          first_flush = flush;
        end else begin
          check("no_stray_flush", {63'd0, flush}, 64'd0);
        end
        if (bus.resp_valid && bus.resp_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_resp: got rdata 0x%0h, expected no response", bus.resp_rdata);
          end else begin
            mon_e = exp_q.pop_front();
            check($sformatf("rdata#%0d", mon_e.tag), {32'd0, bus.resp_rdata}, {32'd0, mon_e.rdata});
            check($sformatf("err#%0d", mon_e.tag), {63'd0, bus.resp_err}, {63'd0, mon_e.err});
            check($sformatf("flush#%0d", mon_e.tag), {63'd0, first_flush}, {63'd0, mon_e.fl});
          end
        end
        held = bus.resp_valid && !bus.resp_ready;
      end
    end
  end

  // ---------------- driver ----------------
  task automatic push_exp(input logic [31:0] er, input logic ee, input logic ef);
    exp_t x;
    x.rdata = er;
    x.err   = ee;
    x.fl    = ef;
    x.tag   = tag_cnt;
    tag_cnt++;
    exp_q.push_back(x);
  endtask

  // Called at posedge+#1; returns at posedge+#1 after the request was accepted.
  task automatic issue(input logic we, input logic [11:0] a, input logic [31:0] wd,
                       input logic [31:0] er, input logic ee, input logic ef);
    int n;
    push_exp(er, ee, ef);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = a;
    bus.req_wdata = wd;
    n = 0;
    @(negedge clk);
    while (!bus.req_ready && n < 20) begin
      n++;
      @(negedge clk);
    end
    if (!bus.req_ready) begin
      checks++;
      errors++;
      $display("FAIL req_timeout: req_ready stuck at 0, expected 1 within 20 cycles");
    end
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      n++;
      @(posedge clk);
    end
    #1;
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d responses outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  localparam logic [31:0] CFG0_WORD = {8'h00, CFG_NA4, 8'h8B, 8'h88};

  initial begin
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_addr   = 12'h000;
    bus.req_wdata  = '0;
    bus.resp_ready = 1'b1;

    // Reset state
    #12;
    check("rst_resp_valid", {63'd0, bus.resp_valid}, 64'd0);
    check("rst_resp_rdata", {32'd0, bus.resp_rdata}, 64'd0);
    check("rst_resp_err",   {63'd0, bus.resp_err}, 64'd0);
    check("rst_flush",      {63'd0, flush}, 64'd0);
    check("rst_req_ready",  {63'd0, bus.req_ready}, 64'd1);
    check("rst_conf",       conf[7:0], 64'd0);
    check("rst_conf_addr0", {32'd0, conf_addr[0]}, 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Reads after reset
    issue(1'b0, 12'h3A0, 32'h0, 32'h0, 1'b0, 1'b0);
    issue(1'b0, 12'h3B0, 32'h0, 32'h0, 1'b0, 1'b0);

    // Basic writes
    issue(1'b1, 12'h3A0, 32'h0000_0F0F, 32'h0000_0F0F, 1'b0, 1'b1);
    issue(1'b1, 12'h3B1, 32'h0000_1234, 32'h0000_1234, 1'b0, 1'b1);
    drain();
    check("cfg0_0f",   {56'd0, conf[0]}, 64'h0F);
    check("cfg1_0f",   {56'd0, conf[1]}, 64'h0F);
    check("addr1",     {32'd0, conf_addr[1]}, 64'h1234);

    // Lock cfg1 as TOR: pmpaddr0 and pmpaddr1 become read-only
    issue(1'b1, 12'h3A0, 32'h0000_8B0F, 32'h0000_8B0F, 1'b0, 1'b1);
    issue(1'b1, 12'h3B0, 32'h0000_FFFF, 32'h0000_0000, 1'b0, 1'b0);
    issue(1'b1, 12'h3B1, 32'h0000_FFFF, 32'h0000_1234, 1'b0, 1'b0);

    // R=0/W=1 on unlocked cfg0; locked cfg1 byte keeps 0x8B
    issue(1'b1, 12'h3A0, 32'h0000_0002, {16'h0, 8'h8B, CFG_W_ONLY}, 1'b0, 1'b1);
    // Reserved bits cleared, L set in cfg0
    issue(1'b1, 12'h3A0, 32'h0000_00E8, 32'h0000_8B88, 1'b0, 1'b1);
    issue(1'b0, 12'h3A0, 32'h0, 32'h0000_8B88, 1'b0, 1'b0);
    issue(1'b1, 12'h3A0, 32'h0000_0000, 32'h0000_8B88, 1'b0, 1'b0);
    // NA4 on cfg2
    issue(1'b1, 12'h3A0, 32'h0010_0000, CFG0_WORD, 1'b0, (CFG_NA4 != 8'h00));

    // Illegal addresses and hardwired entries
    issue(1'b0, 12'h3A5, 32'h0, 32'h0, 1'b1, 1'b0);
    issue(1'b1, 12'h3A5, 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0);
    issue(1'b1, 12'h3C0, 32'h0000_FFFF, 32'h0, 1'b1, 1'b0);
    issue(1'b0, 12'h3A3, 32'h0, 32'h0, 1'b0, 1'b0);
    issue(1'b1, 12'h3B5, 32'h0000_ABCD, 32'h0, 1'b0, 1'b0);
    issue(1'b0, 12'h3B5, 32'h0, 32'h0, 1'b0, 1'b0);
    issue(1'b1, 12'h3A1, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b0);
    drain();
    check("cfg0_88",       {56'd0, conf[0]}, 64'h88);
    check("cfg1_8b",       {56'd0, conf[1]}, 64'h8B);
    check("cfg4_zero",     {56'd0, conf[4]}, 64'h00);
    check("addr0_kept",    {32'd0, conf_addr[0]}, 64'h0);
    check("addr1_kept",    {32'd0, conf_addr[1]}, 64'h1234);
    check("addr5_zero",    {32'd0, conf_addr[5]}, 64'h0);

    // Response backpressure with a pending request
    bus.resp_ready = 1'b0;
    issue(1'b0, 12'h3B1, 32'h0, 32'h0000_1234, 1'b0, 1'b0);
    push_exp(CFG0_WORD, 1'b0, 1'b0);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_addr  = 12'h3A0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_req_ready",  {63'd0, bus.req_ready}, 64'd0);
      check("bp_resp_valid", {63'd0, bus.resp_valid}, 64'd1);
      check("bp_resp_rdata", {32'd0, bus.resp_rdata}, 64'h1234);
    end
    @(posedge clk);
    #1;
    bus.resp_ready = 1'b1;
    @(negedge clk);
    check("bp_same_cycle_ready", {63'd0, bus.req_ready}, 64'd1);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    drain();

    // Reset while a write response is waiting
    bus.resp_ready = 1'b0;
    issue(1'b1, 12'h3B2, 32'h0000_0055, 32'h0000_0055, 1'b0, 1'b1);
    check("pre_rst_addr2", {32'd0, conf_addr[2]}, 64'h55);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_resp_valid", {63'd0, bus.resp_valid}, 64'd0);
    check("midrst_req_ready",  {63'd0, bus.req_ready}, 64'd1);
    check("midrst_addr2",      {32'd0, conf_addr[2]}, 64'h0);
    check("midrst_cfg1",       {56'd0, conf[1]}, 64'h0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.resp_ready = 1'b1;
    issue(1'b0, 12'h3B2, 32'h0, 32'h0, 1'b0, 1'b0);
    issue(1'b0, 12'h3A0, 32'h0, 32'h0, 1'b0, 1'b0);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running, expected completion");
    $fatal(1, "timeout");
  end

endmodule
